mem_arbiter: RTL and testbench

// - Shares the single-port 32-bit memory (clk, write_enable, addr, write_data,

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single-port
// memory with combinational read. Optional macro: MEM_ARB_RR_EN (round-robin).
module mem_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_req_valid,
   input  logic [N-1:0] i_req_addr,
   output logic         i_req_ready,
   output logic         i_resp_valid,
   output logic [N-1:0] i_resp_data,
   input  logic         d_req_valid,
   input  logic         d_req_we,
   input  logic [N-1:0] d_req_addr,
   input  logic [N-1:0] d_req_wdata,
   output logic         d_req_ready,
   output logic         d_resp_valid,
   output logic [N-1:0] d_resp_data,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_write_data,
   output logic         mem_write_enable,
   input  logic [N-1:0] mem_read_data,
   output logic         dbg_state_o
);

   // Handshake: a request is accepted in any cycle where valid && ready are
   // both high; the matching response pulses exactly one cycle later.

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   state_t         state_q, state_d;
   owner_t         owner_q, owner_d;
   owner_t         last_grant_q, last_grant_d;
   logic [N-1:0]   i_resp_data_q, i_resp_data_d;
   logic [N-1:0]   d_resp_data_q, d_resp_data_d;

   logic           any_req;
   logic           win_d;

   // Reset also blocks grants so nothing is accepted while reset is held.
   assign any_req = !reset && (i_req_valid || d_req_valid);

`ifdef MEM_ARB_RR_EN
   assign win_d = (i_req_valid && d_req_valid) ? (last_grant_q == OWN_I) : d_req_valid;
`else
   assign win_d = d_req_valid;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWN_I;
         last_grant_q  <= OWN_I;
         i_resp_data_q <= '0;
         d_resp_data_q <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         i_resp_data_q <= i_resp_data_d;
         d_resp_data_q <= d_resp_data_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      i_resp_data_d = i_resp_data_q;
      d_resp_data_d = d_resp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d      = ST_RESP;
               owner_d      = win_d ? OWN_D : OWN_I;
               last_grant_d = win_d ? OWN_D : OWN_I;
               if (win_d) begin
                  d_resp_data_d = d_req_we ? '0 : mem_read_data;
               end else begin
                  i_resp_data_d = mem_read_data;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      i_req_ready      = 1'b0;
      d_req_ready      = 1'b0;
      i_resp_valid     = 1'b0;
      d_resp_valid     = 1'b0;
      mem_addr         = '0;
      mem_write_data   = '0;
      mem_write_enable = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               if (win_d) begin
                  d_req_ready      = 1'b1;
                  mem_addr         = d_req_addr;
                  mem_write_data   = d_req_wdata;
                  mem_write_enable = d_req_we;
               end else begin
                  i_req_ready      = 1'b1;
                  mem_addr         = i_req_addr;
               end
            end
         end
         ST_RESP: begin
            i_resp_valid = (owner_q == OWN_I);
            d_resp_valid = (owner_q == OWN_D);
         end
         default: ;
      endcase
   end

   assign i_resp_data = i_resp_data_q;
   assign d_resp_data = d_resp_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory attached.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_valid;
   logic [31:0] i_req_addr;
   logic        i_req_ready;
   logic        i_resp_valid;
   logic [31:0] i_resp_data;
   logic        d_req_valid;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_req_ready;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;
   logic        dbg_state;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:15] = '{default: 32'h0};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_addr[3:0]] <= mem_write_data;
   end
   assign mem_read_data = mem[mem_addr[3:0]];

   mem_arbiter #(.N(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .i_req_valid      (i_req_valid),
      .i_req_addr       (i_req_addr),
      .i_req_ready      (i_req_ready),
      .i_resp_valid     (i_resp_valid),
      .i_resp_data      (i_resp_data),
      .d_req_valid      (d_req_valid),
      .d_req_we         (d_req_we),
      .d_req_addr       (d_req_addr),
      .d_req_wdata      (d_req_wdata),
      .d_req_ready      (d_req_ready),
      .d_resp_valid     (d_resp_valid),
      .d_resp_data      (d_resp_data),
      .mem_addr         (mem_addr),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data),
      .dbg_state_o      (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   // Issue one D access from IDLE and check grant and response cycles.
   task automatic d_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
      d_req_valid = 1'b1;
      d_req_we    = we;
      d_req_addr  = addr;
      d_req_wdata = wdata;
      @(negedge clk);
      check("d_grant_ready", d_req_ready, 1);
      check("d_grant_i_ready", i_req_ready, 0);
      check("d_grant_mem_addr", mem_addr, addr);
      check("d_grant_mem_we", mem_write_enable, we);
      next_cycle();
      d_req_valid = 1'b0;
      @(negedge clk);
      check("d_resp_valid", d_resp_valid, 1);
      check("d_resp_data", d_resp_data, exp_data);
      check("d_resp_i_valid", i_resp_valid, 0);
      check("d_resp_ready", d_req_ready, 0);
      check("d_resp_mem_we", mem_write_enable, 0);
      next_cycle();
   endtask

   task automatic i_read(input logic [31:0] addr, input logic [31:0] exp_data);
      i_req_valid = 1'b1;
      i_req_addr  = addr;
      @(negedge clk);
      check("i_grant_ready", i_req_ready, 1);
      check("i_grant_d_ready", d_req_ready, 0);
      check("i_grant_mem_addr", mem_addr, addr);
      check("i_grant_mem_we", mem_write_enable, 0);
      next_cycle();
      i_req_valid = 1'b0;
      @(negedge clk);
      check("i_resp_valid", i_resp_valid, 1);
      check("i_resp_data", i_resp_data, exp_data);
      check("i_resp_d_valid", d_resp_valid, 0);
      check("i_resp_mem_we", mem_write_enable, 0);
      next_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_d;
      reset       = 1'b1;
      i_req_valid = 1'b0;
      i_req_addr  = '0;
      d_req_valid = 1'b0;
      d_req_we    = 1'b0;
      d_req_addr  = '0;
      d_req_wdata = '0;

      // Reset values, with a request pending that must not be granted.
      next_cycle();
      d_req_valid = 1'b1;
      @(negedge clk);
      check("rst_state", dbg_state, 0);
      check("rst_i_ready", i_req_ready, 0);
      check("rst_d_ready", d_req_ready, 0);
      check("rst_i_resp_valid", i_resp_valid, 0);
      check("rst_d_resp_valid", d_resp_valid, 0);
      check("rst_mem_we", mem_write_enable, 0);
      check("rst_i_resp_data", i_resp_data, 0);
      check("rst_d_resp_data", d_resp_data, 0);
      d_req_valid = 1'b0;
      next_cycle();
      reset = 1'b0;

      // Idle outputs.
      @(negedge clk);
      check("idle_mem_addr", mem_addr, 0);
      check("idle_state", dbg_state, 0);
      next_cycle();

      d_access(1'b1, 32'd1, 32'hDEADBEEF, 32'h0);
      i_read(32'd1, 32'hDEADBEEF);
      d_access(1'b1, 32'd2, 32'h12345678, 32'h0);
      check("i_resp_data_hold", i_resp_data, 32'hDEADBEEF);
      d_access(1'b0, 32'd2, 32'h0, 32'h12345678);
      i_read(32'd1, 32'hDEADBEEF);
      d_access(1'b0, 32'd3, 32'h0, 32'h0);
      check("d_resp_data_hold", d_resp_data, 32'h0);

      // Contention from a fresh reset, both ports continuously valid.
      reset_pulse();
      i_req_valid = 1'b1;
      i_req_addr  = 32'd1;
      d_req_valid = 1'b1;
      d_req_we    = 1'b0;
      d_req_addr  = 32'd2;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         @(negedge clk);
         check("cont_d_ready", d_req_ready, exp_d);
         check("cont_i_ready", i_req_ready, !exp_d);
         check("cont_mem_addr", mem_addr, exp_d ? 32'd2 : 32'd1);
         next_cycle();
         @(negedge clk);
         check("cont_d_resp_valid", d_resp_valid, exp_d);
         check("cont_i_resp_valid", i_resp_valid, !exp_d);
         check("cont_ready_low", {i_req_ready, d_req_ready}, 0);
         if (exp_d) check("cont_d_data", d_resp_data, 32'h12345678);
         else check("cont_i_data", i_resp_data, 32'hDEADBEEF);
         next_cycle();
      end
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;

      // Reset in the response cycle of a store.
      d_req_valid = 1'b1;
      d_req_we    = 1'b1;
      d_req_addr  = 32'd5;
      d_req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      check("mid_grant_ready", d_req_ready, 1);
      next_cycle();
      d_req_valid = 1'b0;
      d_req_we    = 1'b0;
      check("mid_resp_valid", d_resp_valid, 1);
      check("mid_resp_state", dbg_state, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_resp_valid", d_resp_valid, 0);
      check("mid_rst_state", dbg_state, 0);
      check("mid_rst_d_data", d_resp_data, 0);
      next_cycle();
      reset = 1'b0;
      d_access(1'b0, 32'd5, 32'h0, 32'hCAFEF00D);
      i_read(32'd1, 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
